// File: rtl/circuito_exp6_pkg.sv
// Shared types and constants for the memory game (circuito_exp6).
package circuito_exp6_pkg;

  localparam int unsigned TIMEOUT   = 5000;
  localparam int unsigned T_MOSTRA  = 1000;
  localparam int unsigned N_RODADAS = 16;

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned TIMER_W = 13;
  localparam int unsigned SEG_W   = 7;

  // Word stored at address 0; it is never overwritten by a game
  localparam logic [DATA_W-1:0] MEM0_INIT     = DATA_W'(4'b0001);
  localparam logic [ADDR_W-1:0] ULTIMA_RODADA = ADDR_W'(N_RODADAS - 1);

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    MOSTRA        = 4'h2,
    ESPERA        = 4'h3,
    REGISTRA      = 4'h4,
    COMPARA       = 4'h5,
    PROXIMO       = 4'h6,
    ESPERA_NOVA   = 4'h7,
    REGISTRA_NOVA = 4'h8,
    GRAVA         = 4'h9,
    PROX_RODADA   = 4'hA,
    FIM_GANHOU    = 4'hB,
    FIM_TIMEOUT   = 4'hD,
    FIM_PERDEU    = 4'hE
  } estado_t;

  // Commands from the control unit to the datapath
  typedef struct packed {
    logic zera_contadores;
    logic zera_timer;
    logic conta_timer;
    logic inc_endereco;
    logic zera_endereco;
    logic inc_rodada;
    logic grava;
    logic mostra_prox;
  } ctrl_t;

  // Conditions reported by the datapath to the control unit
  typedef struct packed {
    logic jogada;
    logic igual;
    logic endereco_igual_rodada;
    logic rodada_final;
    logic fim_mostra;
    logic timeout;
  } status_t;

endpackage

// File: rtl/circuito_exp6_if.sv
// Control/status link between the control unit and the datapath.
interface circuito_exp6_if;
  import circuito_exp6_pkg::*;

  ctrl_t   ctrl_c;
  status_t status_c;

  modport uc (output ctrl_c, input status_c);
  modport fd (input ctrl_c, output status_c);
endinterface

// File: rtl/circuito_exp6_jogo_if.sv
// Player-facing signal bundle of the game.
interface circuito_exp6_jogo_if;
  import circuito_exp6_pkg::*;

  logic              iniciar;
  logic [DATA_W-1:0] botoes;
  logic [DATA_W-1:0] leds;
  logic              pronto;
  logic              ganhou;
  logic              perdeu;

  modport jogador (output iniciar, botoes, input leds, pronto, ganhou, perdeu);
  modport jogo    (input iniciar, botoes, output leds, pronto, ganhou, perdeu);
endinterface

// File: rtl/circuito_exp6_fd.sv
// Datapath: counters, timer, play register, pattern RAM and leds.
module circuito_exp6_fd
  import circuito_exp6_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] botoes_i,
  circuito_exp6_if.fd       bus,
  output logic [DATA_W-1:0] leds_o,
  output logic [ADDR_W-1:0] endereco_o,
  output logic [ADDR_W-1:0] rodada_o,
  output logic [DATA_W-1:0] memoria_o,
  output logic [DATA_W-1:0] jogada_o
);

  ctrl_t              ctrl;
  status_t            status_c;
  logic [ADDR_W-1:0]  endereco_q, endereco_d;
  logic [ADDR_W-1:0]  rodada_q, rodada_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [DATA_W-1:0]  jogada_q, jogada_d;
  logic [DATA_W-1:0]  leds_q, leds_d;
  logic               tem_jogada_q;
  logic               jogada_c;
  logic [DATA_W-1:0]  memoria_c;
  logic [DATA_W-1:0]  mem_q [N_RODADAS];

  assign ctrl = bus.ctrl_c;

  // A play is the rising edge of any button; holding a button stays one play
  assign jogada_c  = (|botoes_i) & ~tem_jogada_q;

  // Address 0 is never a write target, so its image is hardwired
  assign memoria_c = (endereco_q == '0) ? MEM0_INIT : mem_q[endereco_q];

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      endereco_q   <= '0;
      rodada_q     <= '0;
      timer_q      <= '0;
      jogada_q     <= '0;
      leds_q       <= '0;
      tem_jogada_q <= 1'b0;
    end else begin
      endereco_q   <= endereco_d;
      rodada_q     <= rodada_d;
      timer_q      <= timer_d;
      jogada_q     <= jogada_d;
      leds_q       <= leds_d;
      tem_jogada_q <= |botoes_i;
    end
  end

  // Pattern RAM write port; contents survive reset
  always_ff @(posedge clock) begin
    if (ctrl.grava) mem_q[rodada_q + ADDR_W'(1)] <= jogada_q;
  end

  // Next values for counters, timer, play register and leds
  always_comb begin
    endereco_d = endereco_q;
    rodada_d   = rodada_q;
    timer_d    = timer_q;
    jogada_d   = jogada_q;
    leds_d     = ctrl.mostra_prox ? MEM0_INIT : botoes_i;

    if (ctrl.zera_contadores) begin
      endereco_d = '0;
      rodada_d   = '0;
    end else begin
      if (ctrl.zera_endereco)     endereco_d = '0;
      else if (ctrl.inc_endereco) endereco_d = endereco_q + ADDR_W'(1);
      if (ctrl.inc_rodada && (rodada_q != ULTIMA_RODADA))
        rodada_d = rodada_q + ADDR_W'(1);
    end

    if (ctrl.zera_timer || ctrl.zera_contadores) timer_d = '0;
    else if (ctrl.conta_timer && (timer_q != '1)) timer_d = timer_q + TIMER_W'(1);

    if (jogada_c) jogada_d = botoes_i;
  end

  // Status back to the control unit
  always_comb begin
    status_c                       = '0;
    status_c.jogada                = jogada_c;
    status_c.igual                 = (jogada_q == memoria_c);
    status_c.endereco_igual_rodada = (endereco_q == rodada_q);
    status_c.rodada_final          = (rodada_q == ULTIMA_RODADA);
    status_c.fim_mostra            = (timer_q == TIMER_W'(T_MOSTRA - 1));
    status_c.timeout               = (timer_q == TIMER_W'(TIMEOUT - 1));
  end

  assign bus.status_c = status_c;
  assign leds_o       = leds_q;
  assign endereco_o   = endereco_q;
  assign rodada_o     = rodada_q;
  assign memoria_o    = memoria_c;
  assign jogada_o     = jogada_q;

endmodule

// File: rtl/circuito_exp6_uc.sv
// Control unit: game sequencing FSM and registered end-of-game flags.
module circuito_exp6_uc
  import circuito_exp6_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar_i,
  circuito_exp6_if.uc bus,
  output logic [3:0]  estado_o,
  output logic        pronto_o,
  output logic        ganhou_o,
  output logic        perdeu_o,
  output logic        timeout_o
);

  estado_t estado_q, estado_d;
  logic    pronto_q, pronto_d;
  logic    ganhou_q, ganhou_d;
  logic    perdeu_q, perdeu_d;
  logic    timeout_q, timeout_d;
  ctrl_t   ctrl_c;
  status_t st;

  assign st = bus.status_c;

  // State and flag registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      pronto_q  <= 1'b0;
      ganhou_q  <= 1'b0;
      perdeu_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      pronto_q  <= pronto_d;
      ganhou_q  <= ganhou_d;
      perdeu_q  <= perdeu_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:       if (iniciar_i) estado_d = PREPARACAO;
      PREPARACAO:    estado_d = MOSTRA;
      MOSTRA:        if (st.fim_mostra) estado_d = ESPERA;
      ESPERA: begin
        if (st.jogada)       estado_d = REGISTRA;
        else if (st.timeout) estado_d = FIM_TIMEOUT;
      end
      REGISTRA:      estado_d = COMPARA;
      COMPARA: begin
        if (!st.igual)                      estado_d = FIM_PERDEU;
        else if (!st.endereco_igual_rodada) estado_d = PROXIMO;
        else if (st.rodada_final)           estado_d = FIM_GANHOU;
        else                                estado_d = ESPERA_NOVA;
      end
      PROXIMO:       estado_d = ESPERA;
      ESPERA_NOVA: begin
        if (st.jogada)       estado_d = REGISTRA_NOVA;
        else if (st.timeout) estado_d = FIM_TIMEOUT;
      end
      REGISTRA_NOVA: estado_d = GRAVA;
      GRAVA:         estado_d = PROX_RODADA;
      PROX_RODADA:   estado_d = ESPERA;
      FIM_GANHOU, FIM_TIMEOUT, FIM_PERDEU:
                     if (iniciar_i) estado_d = PREPARACAO;
      default:       estado_d = INICIAL;
    endcase
  end

  // End-of-game flags, decoded from the state being entered so they align with it
  always_comb begin
    pronto_d  = 1'b0;
    ganhou_d  = 1'b0;
    perdeu_d  = 1'b0;
    timeout_d = 1'b0;
    case (estado_d)
      FIM_GANHOU: begin
        pronto_d = 1'b1;
        ganhou_d = 1'b1;
      end
      FIM_PERDEU: begin
        pronto_d = 1'b1;
        perdeu_d = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto_d  = 1'b1;
        perdeu_d  = 1'b1;
        timeout_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath commands; the timer restarts on every state change
  always_comb begin
    ctrl_c             = '0;
    ctrl_c.zera_timer  = (estado_d != estado_q);
    ctrl_c.mostra_prox = (estado_d == MOSTRA);
    case (estado_q)
      PREPARACAO:                  ctrl_c.zera_contadores = 1'b1;
      MOSTRA, ESPERA, ESPERA_NOVA: ctrl_c.conta_timer     = 1'b1;
      PROXIMO:                     ctrl_c.inc_endereco    = 1'b1;
      GRAVA:                       ctrl_c.grava           = 1'b1;
      PROX_RODADA: begin
        ctrl_c.inc_rodada    = 1'b1;
        ctrl_c.zera_endereco = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ctrl_c = ctrl_c;
  assign estado_o   = estado_q;
  assign pronto_o   = pronto_q;
  assign ganhou_o   = ganhou_q;
  assign perdeu_o   = perdeu_q;
  assign timeout_o  = timeout_q;

endmodule

// File: rtl/hexa7seg.sv
// Hex digit to 7-segment decoder, gfedcba, active-low.
module hexa7seg
  import circuito_exp6_pkg::*;
(
  input  logic [3:0]       hexa_i,
  output logic [SEG_W-1:0] display_o
);

  // Segment lookup
  always_comb begin
    display_o = 7'b1111111;
    case (hexa_i)
      4'h0: display_o = 7'b1000000;
      4'h1: display_o = 7'b1111001;
      4'h2: display_o = 7'b0100100;
      4'h3: display_o = 7'b0110000;
      4'h4: display_o = 7'b0011001;
      4'h5: display_o = 7'b0010010;
      4'h6: display_o = 7'b0000010;
      4'h7: display_o = 7'b1111000;
      4'h8: display_o = 7'b0000000;
      4'h9: display_o = 7'b0010000;
      4'hA: display_o = 7'b0001000;
      4'hB: display_o = 7'b0000011;
      4'hC: display_o = 7'b1000110;
      4'hD: display_o = 7'b0100001;
      4'hE: display_o = 7'b0000110;
      4'hF: display_o = 7'b0001110;
      default: display_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/circuito_exp6.sv
// Memory game top: control unit, datapath and debug displays.
module circuito_exp6
  import circuito_exp6_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [DATA_W-1:0] botoes,
  output logic [DATA_W-1:0] leds,
  output logic              pronto,
  output logic              ganhou,
  output logic              perdeu,
  output logic              db_clock,
  output logic              db_tem_jogada,
  output logic              db_igual,
  output logic              db_enderecoIgualRodada,
  output logic              db_timeout,
  output logic [SEG_W-1:0]  db_contagem,
  output logic [SEG_W-1:0]  db_memoria,
  output logic [SEG_W-1:0]  db_jogadafeita,
  output logic [SEG_W-1:0]  db_rodada,
  output logic [SEG_W-1:0]  db_estado
);

  circuito_exp6_if bus ();

  logic [3:0]        estado;
  logic [ADDR_W-1:0] endereco;
  logic [ADDR_W-1:0] rodada;
  logic [DATA_W-1:0] memoria;
  logic [DATA_W-1:0] jogada;

  circuito_exp6_uc u_uc (
    .clock     (clock),
    .reset     (reset),
    .iniciar_i (iniciar),
    .bus       (bus),
    .estado_o  (estado),
    .pronto_o  (pronto),
    .ganhou_o  (ganhou),
    .perdeu_o  (perdeu),
    .timeout_o (db_timeout)
  );

  circuito_exp6_fd u_fd (
    .clock      (clock),
    .reset      (reset),
    .botoes_i   (botoes),
    .bus        (bus),
    .leds_o     (leds),
    .endereco_o (endereco),
    .rodada_o   (rodada),
    .memoria_o  (memoria),
    .jogada_o   (jogada)
  );

  hexa7seg u_hex_contagem (.hexa_i(endereco), .display_o(db_contagem));
  hexa7seg u_hex_memoria  (.hexa_i(memoria),  .display_o(db_memoria));
  hexa7seg u_hex_jogada   (.hexa_i(jogada),   .display_o(db_jogadafeita));
  hexa7seg u_hex_rodada   (.hexa_i(rodada),   .display_o(db_rodada));
  hexa7seg u_hex_estado   (.hexa_i(estado),   .display_o(db_estado));

  assign db_clock               = clock;
  assign db_tem_jogada          = |botoes;
  assign db_igual               = bus.status_c.igual;
  assign db_enderecoIgualRodada = bus.status_c.endereco_igual_rodada;

endmodule

// File: tb/tb_circuito_exp6.sv
// Directed bench for the memory game with an expected-value scoreboard.
module tb_circuito_exp6;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  circuito_exp6_jogo_if jg ();

  logic       db_clock, db_tem_jogada, db_igual, db_enderecoIgualRodada, db_timeout;
  logic [6:0] db_contagem, db_memoria, db_jogadafeita, db_rodada, db_estado;

  circuito_exp6 dut (
    .clock                  (clock),
    .reset                  (reset),
    .iniciar                (jg.iniciar),
    .botoes                 (jg.botoes),
    .leds                   (jg.leds),
    .pronto                 (jg.pronto),
    .ganhou                 (jg.ganhou),
    .perdeu                 (jg.perdeu),
    .db_clock               (db_clock),
    .db_tem_jogada          (db_tem_jogada),
    .db_igual               (db_igual),
    .db_enderecoIgualRodada (db_enderecoIgualRodada),
    .db_timeout             (db_timeout),
    .db_contagem            (db_contagem),
    .db_memoria             (db_memoria),
    .db_jogadafeita         (db_jogadafeita),
    .db_rodada              (db_rodada),
    .db_estado              (db_estado)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  // Reference 7-segment codes, gfedcba active-low
  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // New plays: 0100, 0001, 1000, 1000, repeating
  function automatic logic [3:0] nova(input int j);
    case (j % 4)
      0:       return 4'b0100;
      1:       return 4'b0001;
      default: return 4'b1000;
    endcase
  endfunction

  // Sequence entry k of the stored pattern
  function automatic logic [3:0] padrao(input int k);
    return (k == 0) ? 4'b0001 : nova(k - 1);
  endfunction

  task automatic sb_push(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%0h required=%0h", t, obs, e);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One play: press for 'hold' cycles, then release long enough to return to a wait state
  task automatic joga(input logic [3:0] b, input int hold);
    jg.botoes = b;
    ciclos(hold);
    jg.botoes = 4'b0000;
    ciclos(5);
  endtask

  // Wait until db_estado shows 'st', bounded by 'max' cycles
  task automatic aguarda(input logic [3:0] st, input int max, output int n);
    n = 0;
    while (db_estado !== seg(st) && n < max) begin
      @(negedge clock);
      n++;
    end
  endtask

  int  n, cnt2, cntled;
  bit  saw3;

  initial begin
    reset      = 1'b0;
    jg.iniciar = 1'b0;
    jg.botoes  = 4'b0000;
    ciclos(3);

    // Reset state
    sb_push("rst_estado", 32'(seg(4'h0))); sb_check(32'(db_estado));
    sb_push("rst_leds", 0);               sb_check(32'(jg.leds));
    sb_push("rst_pronto", 0);             sb_check(32'(jg.pronto));
    sb_push("rst_perdeu", 0);             sb_check(32'(jg.perdeu));
    reset = 1'b1;
    ciclos(2);

    // Start: mostra lasts 1000 cycles with leds = 0001, then espera
    jg.iniciar = 1'b1;
    cnt2 = 0; cntled = 0; saw3 = 1'b0;
    for (int i = 0; i < 1200 && !saw3; i++) begin
      @(negedge clock);
      if (i == 9) jg.iniciar = 1'b0;
      if (db_estado === seg(4'h2)) begin
        cnt2++;
        if (jg.leds === 4'b0001) cntled++;
      end
      if (db_estado === seg(4'h3)) saw3 = 1'b1;
    end
    jg.iniciar = 1'b0;
    sb_push("mostra_ciclos", 1000);       sb_check(32'(cnt2));
    sb_push("mostra_leds", 1000);         sb_check(32'(cntled));
    sb_push("espera_estado", 32'(seg(4'h3))); sb_check(32'(db_estado));
    sb_push("espera_leds", 0);            sb_check(32'(jg.leds));

    // Full winning game
    for (int r = 0; r < 16; r++) begin
      sb_push($sformatf("rodada_%0d", r), 32'(seg(4'(r)))); sb_check(32'(db_rodada));
      for (int k = 0; k <= r; k++) begin
        joga(padrao(k), 2);
        if (r == 2 && k == 0) begin
          sb_push("contagem_r2", 32'(seg(4'h1)));   sb_check(32'(db_contagem));
          sb_push("memoria_r2", 32'(seg(4'h4)));    sb_check(32'(db_memoria));
          sb_push("jogadafeita_r2", 32'(seg(4'h1))); sb_check(32'(db_jogadafeita));
        end
      end
      if (r < 15) begin
        sb_push($sformatf("espera_nova_%0d", r), 32'(seg(4'h7))); sb_check(32'(db_estado));
        joga(nova(r), 2);
      end
    end
    sb_push("win_estado", 32'(seg(4'hB))); sb_check(32'(db_estado));
    sb_push("win_ganhou", 1);              sb_check(32'(jg.ganhou));
    sb_push("win_pronto", 1);              sb_check(32'(jg.pronto));
    sb_push("win_perdeu", 0);              sb_check(32'(jg.perdeu));

    // New game: held button is one play, then a wrong play in round 1
    jg.iniciar = 1'b1;
    aguarda(4'h3, 1500, n);
    jg.iniciar = 1'b0;
    sb_push("jogo2_espera", 32'(seg(4'h3))); sb_check(32'(db_estado));
    joga(4'b0001, 2);
    joga(nova(0), 2);
    joga(4'b0001, 10);
    sb_push("held_contagem", 32'(seg(4'h1))); sb_check(32'(db_contagem));
    sb_push("held_estado", 32'(seg(4'h3)));   sb_check(32'(db_estado));
    joga(4'b0010, 2);
    sb_push("lose_estado", 32'(seg(4'hE))); sb_check(32'(db_estado));
    sb_push("lose_perdeu", 1);              sb_check(32'(jg.perdeu));
    sb_push("lose_pronto", 1);              sb_check(32'(jg.pronto));
    sb_push("lose_ganhou", 0);              sb_check(32'(jg.ganhou));
    sb_push("lose_timeout", 0);             sb_check(32'(db_timeout));

    // Timeout: no press for 5000 cycles in espera
    jg.iniciar = 1'b1;
    aguarda(4'h3, 1500, n);
    jg.iniciar = 1'b0;
    aguarda(4'hD, 6000, n);
    sb_push("timeout_ciclos", 5000);         sb_check(32'(n));
    sb_push("timeout_estado", 32'(seg(4'hD))); sb_check(32'(db_estado));
    sb_push("timeout_flag", 1);              sb_check(32'(db_timeout));
    sb_push("timeout_perdeu", 1);            sb_check(32'(jg.perdeu));
    sb_push("timeout_pronto", 1);            sb_check(32'(jg.pronto));

    // Reset in the middle of round 5
    jg.iniciar = 1'b1;
    aguarda(4'h3, 1500, n);
    jg.iniciar = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k <= r; k++) joga(padrao(k), 2);
      joga(nova(r), 2);
    end
    joga(padrao(0), 2);
    joga(padrao(1), 2);
    sb_push("r5_rodada", 32'(seg(4'h5)));   sb_check(32'(db_rodada));
    sb_push("r5_contagem", 32'(seg(4'h2))); sb_check(32'(db_contagem));
    jg.botoes = 4'b0001;
    reset     = 1'b0;
    #1;
    sb_push("mid_rst_estado", 32'(seg(4'h0)));   sb_check(32'(db_estado));
    sb_push("mid_rst_rodada", 32'(seg(4'h0)));   sb_check(32'(db_rodada));
    sb_push("mid_rst_contagem", 32'(seg(4'h0))); sb_check(32'(db_contagem));
    sb_push("mid_rst_jogada", 32'(seg(4'h0)));   sb_check(32'(db_jogadafeita));
    sb_push("mid_rst_leds", 0);                  sb_check(32'(jg.leds));
    sb_push("mid_rst_pronto", 0);                sb_check(32'(jg.pronto));
    sb_push("mid_rst_ganhou", 0);                sb_check(32'(jg.ganhou));
    sb_push("mid_rst_perdeu", 0);                sb_check(32'(jg.perdeu));
    sb_push("mid_rst_timeout", 0);               sb_check(32'(db_timeout));
    jg.botoes = 4'b0000;
    ciclos(2);
    reset = 1'b1;
    ciclos(3);
    sb_push("post_rst_estado", 32'(seg(4'h0))); sb_check(32'(db_estado));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/circuito_exp6.md
CIRCUITO_EXP6 -- requirements
Module: circuito_exp6

Interface
REQ-001 The block SHALL have one clock, clock; reset, named reset, SHALL be asynchronous and active-low.
REQ-002 The ports SHALL be as follows, clock and reset first:
- clock  in  1  system clock, 1 kHz nominal
- reset  in  1  asynchronous active-low reset
- iniciar  in  1  start request, level
- botoes  in  4  player buttons, one-hot when pressed
- leds  out  4  pattern shown to the player
- pronto  out  1  game finished
- ganhou  out  1  win indication
- perdeu  out  1  loss indication (wrong play or timeout)
- db_clock  out  1  copy of clock
- db_tem_jogada  out  1  any button pressed (OR of botoes)
- db_igual  out  1  botoes register equals memory word
- db_enderecoIgualRodada  out  1  play address equals round
- db_timeout  out  1  timeout flag
- db_contagem  out  7  play address, as a 7-segment digit
- db_memoria  out  7  memory output, as a 7-segment digit
- db_jogadafeita  out  7  registered play, as a 7-segment digit
- db_rodada  out  7  round counter, as a 7-segment digit
- db_estado  out  7  FSM state code, as a 7-segment digit
REQ-003 The 7-segment outputs SHALL use order gfedcba, active-low, hex 0-F.

Function
REQ-004 Memory SHALL be a 16x4 synchronous-write RAM with initial image address 0 = 0001 and all other addresses = 0000; reset SHALL NOT clear it.
REQ-005 A play SHALL be the rising edge of the OR of botoes; botoes SHALL be registered on that edge.
REQ-006 The FSM states SHALL be: inicial(0), preparacao(1), mostra(2), espera(3), registra(4), compara(5), proximo(6), espera_nova(7), registra_nova(8), grava(9), prox_rodada(A), fim_ganhou(B), fim_timeout(D), fim_perdeu(E).
REQ-007 In inicial, the FSM SHALL go to preparacao when iniciar=1.
REQ-008 Preparacao SHALL clear the address counter, the round counter and the timer.
REQ-009 Mostra SHALL drive leds = mem[0] for 1000 cycles, then go to espera.
REQ-010 Espera SHALL go to registra on a play, or to fim_timeout after 5000 cycles without a play.
REQ-011 Compare step: registra -> compara; if unequal -> fim_perdeu.
REQ-012 Address check: if equal and address≠round -> proximo, which increments the address and goes to espera.
REQ-013 Round end: if equal, address=round and round=15 -> fim_ganhou.
REQ-014 New play: if equal, address=round and round<15 -> espera_nova.
REQ-015 Espera_nova SHALL go to registra_nova on a play and to fim_timeout after 5000 cycles.
REQ-016 Registra_nova SHALL go to grava, which writes the registered play to mem[round+1].
REQ-017 Prox_rodada SHALL increment the round, clear the address and timer, and go to espera.
REQ-018 The timer SHALL clear on every registered play.
REQ-019 fim_ganhou SHALL assert ganhou and pronto.
REQ-020 fim_perdeu and fim_timeout SHALL assert perdeu and pronto; fim_timeout SHALL additionally hold db_timeout=1.
REQ-021 In any fim_* state, iniciar=1 SHALL go to preparacao with the RAM content kept.
REQ-022 Leds SHALL equal botoes outside mostra.
REQ-023 Counters are 4-bit; the round counter SHALL saturate at 15 with no wrap.
REQ-024 A button held for multiple cycles SHALL count as one play.

Reset
REQ-025 Reset asserted SHALL force inicial, clear all counters, the timer and the play register, and drive every status output and leds to 0, at any time including mid-game.

Structure
REQ-026 A shared package SHALL hold the state encodings and the constants TIMEOUT=5000, T_MOSTRA=1000, N_RODADAS=16.
REQ-027 The datapath SHALL be separate from the FSM; the sub-module hexa7seg SHALL be instantiated 5 times.

Verification
REQ-028 Reset pulse, then iniciar for 10 cycles -> state 2, leds=0001 for 1000 cycles, then state 3.
REQ-029 Full win: each round replays mem[0..i] and then enters new plays 0100, 0001, 1000, 1000, 0100, ... -> after round 15 ganhou=1, pronto=1, perdeu=0.
REQ-030 Round 1: a wrong second play (press 0010 where 0100 is expected) -> perdeu=1, pronto=1, db_estado shows E.
REQ-031 No press for 5000 cycles in espera -> db_timeout=1, perdeu=1, state D.
REQ-032 Reset asserted mid-round 5 -> all outputs 0 and state 0 immediately.
REQ-033 Button held for 10 cycles -> exactly one address increment.
